// File: rtl/fejkon_pcie_tx_arb.sv
// Packet-granular weighted round-robin arbiter sharing the PCIe hard-IP TX
// Avalon-ST port between MMIO completions (A) and data-path TLPs (B).
//
// state | meaning
// IDLE  | no packet in flight; arbitrate sop requests, discard stray beats
// GNT_A | source A owns tx_st_* until its eop beat is accepted
// GNT_B | source B owns tx_st_* until its eop beat is accepted
module fejkon_pcie_tx_arb #(
    parameter int unsigned A_WEIGHT = 2,
    parameter int unsigned B_WEIGHT = 1
) (
    input  logic         clk,
    input  logic         reset_n,

    input  logic [255:0] a_data,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic         a_startofpacket,
    input  logic         a_endofpacket,
    input  logic [1:0]   a_empty,
    input  logic         a_error,

    input  logic [255:0] b_data,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic         b_startofpacket,
    input  logic         b_endofpacket,
    input  logic [1:0]   b_empty,
    input  logic         b_error,

    output logic [255:0] tx_st_data,
    output logic         tx_st_valid,
    input  logic         tx_st_ready,
    output logic         tx_st_startofpacket,
    output logic         tx_st_endofpacket,
    output logic [1:0]   tx_st_empty,
    output logic         tx_st_error,

    output logic [31:0]  pkt_cnt_a,
    output logic [31:0]  pkt_cnt_b,
    output logic [15:0]  drop_cnt
);

    localparam logic [3:0] A_W = 4'(A_WEIGHT);
    localparam logic [3:0] B_W = 4'(B_WEIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_b_q, last_b_d;
    logic [3:0]  run_q, run_d;
    logic [31:0] pkt_cnt_a_q, pkt_cnt_a_d;
    logic [31:0] pkt_cnt_b_q, pkt_cnt_b_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic        req_a, req_b;
    logic        drop_a, drop_b;
    logic        rpt, pick_b, sel_b;
    logic [3:0]  last_w;
    logic [16:0] drop_sum;

    always_comb begin
        state_d     = state_q;
        last_b_d    = last_b_q;
        run_d       = run_q;
        pkt_cnt_a_d = pkt_cnt_a_q;
        pkt_cnt_b_d = pkt_cnt_b_q;
        drop_cnt_d  = drop_cnt_q;
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        tx_st_valid = 1'b0;

        req_a  = a_valid & a_startofpacket;
        req_b  = b_valid & b_startofpacket;
        // Stray beats are only swallowed while out of reset so readies stay low in reset.
        drop_a = reset_n & a_valid & ~a_startofpacket;
        drop_b = reset_n & b_valid & ~b_startofpacket;

        // run==0 means no grant history yet, so the first tie goes to the source != last.
        last_w = last_b_q ? B_W : A_W;
        rpt    = (run_q != 4'd0) && (run_q < last_w);
        if (req_a && req_b) begin
            pick_b = rpt ? last_b_q : ~last_b_q;
        end else begin
            pick_b = req_b;
        end

        drop_sum = {1'b0, drop_cnt_q} + {16'd0, drop_a} + {16'd0, drop_b};

        case (state_q)
            IDLE: begin
                a_ready    = drop_a;
                b_ready    = drop_b;
                drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                if (req_a || req_b) begin
                    state_d  = pick_b ? GNT_B : GNT_A;
                    last_b_d = pick_b;
                    if (pick_b != last_b_q) begin
                        run_d = 4'd1;
                    end else if (run_q != 4'hF) begin
                        run_d = run_q + 4'd1;
                    end
                end
            end
            GNT_A: begin
                tx_st_valid = a_valid;
                a_ready     = tx_st_ready;
                if (a_valid && tx_st_ready && a_endofpacket) begin
                    pkt_cnt_a_d = pkt_cnt_a_q + 32'd1;
                    state_d     = IDLE;
                end
            end
            GNT_B: begin
                tx_st_valid = b_valid;
                b_ready     = tx_st_ready;
                if (b_valid && tx_st_ready && b_endofpacket) begin
                    pkt_cnt_b_d = pkt_cnt_b_q + 32'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_b               = (state_q == GNT_B);
    assign tx_st_data          = sel_b ? b_data          : a_data;
    assign tx_st_startofpacket = sel_b ? b_startofpacket : a_startofpacket;
    assign tx_st_endofpacket   = sel_b ? b_endofpacket   : a_endofpacket;
    assign tx_st_empty         = sel_b ? b_empty         : a_empty;
    assign tx_st_error         = sel_b ? b_error         : a_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            run_q       <= 4'd0;
            pkt_cnt_a_q <= 32'd0;
            pkt_cnt_b_q <= 32'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            last_b_q    <= last_b_d;
            run_q       <= run_d;
            pkt_cnt_a_q <= pkt_cnt_a_d;
            pkt_cnt_b_q <= pkt_cnt_b_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign pkt_cnt_a = pkt_cnt_a_q;
    assign pkt_cnt_b = pkt_cnt_b_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
